// File: rtl/paddle_axis_ctrl_if.sv
// rtl/paddle_axis_ctrl_if.sv - pixel query bus between the raster scanner and one paddle
//   x, y        : current pixel coordinate (driven by the scanner)
//   paddle_on   : current pixel lies inside the paddle (driven by the paddle)
//   rgb_paddle  : paddle colour (driven by the paddle)
interface paddle_axis_ctrl_if;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        paddle_on;
    logic [23:0] rgb_paddle;

    modport master (output x, output y, input paddle_on, input rgb_paddle);
    modport slave  (input x, input y, output paddle_on, output rgb_paddle);
endinterface

// File: rtl/paddle_axis_ctrl.sv
// rtl/paddle_axis_ctrl.sv - single pong paddle: synchronised buttons, accelerating manual motion, AUTO ball tracking
//   clk_1ms    : 1 ms tick, all state on its rising edge
//   reset      : asynchronous, active-low
//   btn_up_n   : up button, active-low, asynchronous
//   btn_dn_n   : down button, active-low, asynchronous
//   auto_mode  : 1 = track ball, 0 = buttons; asynchronous
//   ball_y     : ball centre y for AUTO mode
//   pix        : pixel query bus (x, y in; paddle_on, rgb_paddle out)
//   x_paddle   : paddle centre x (constant)
//   y_paddle   : paddle centre y
//   speed      : current manual step size
//   at_top     : y_paddle at upper limit
//   at_bottom  : y_paddle at lower limit
module paddle_axis_ctrl #(
    parameter int          H_ACTIVE   = 640,
    parameter int          V_ACTIVE   = 480,
    parameter int          PADDLE_W   = 16,
    parameter int          PADDLE_H   = 80,
    parameter int          X_CENTER   = 28,
    parameter int          MAX_SPEED  = 4,
    parameter int          ACCEL_MS   = 64,
    parameter int          AUTO_SPEED = 2,
    parameter int          DEAD_ZONE  = 4,
    parameter logic [23:0] COLOR      = 24'hFF0000
) (
    input  logic                 clk_1ms,
    input  logic                 reset,
    input  logic                 btn_up_n,
    input  logic                 btn_dn_n,
    input  logic                 auto_mode,
    input  logic [9:0]           ball_y,
    paddle_axis_ctrl_if.slave    pix,
    output logic [9:0]           x_paddle,
    output logic [9:0]           y_paddle,
    output logic [3:0]           speed,
    output logic                 at_top,
    output logic                 at_bottom
);
    localparam int CW = $clog2(ACCEL_MS + 1);
    localparam logic signed [10:0] YMIN_S = 11'(PADDLE_H / 2);
    localparam logic signed [10:0] YMAX_S = 11'(V_ACTIVE - PADDLE_H / 2);
    localparam logic signed [10:0] AUTO_S = 11'(AUTO_SPEED);
    localparam logic signed [10:0] DZ_S   = 11'(DEAD_ZONE);

    typedef enum logic [1:0] {IDLE, UP, DOWN} dir_t;

    dir_t           state_q, state_d;
    logic [9:0]     y_q, y_d;
    logic [3:0]     speed_q, speed_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic           top_q, top_d, bot_q, bot_d;
    logic           up_s1_q, up_s2_q, dn_s1_q, dn_s2_q, mode_s1_q, mode_s2_q;

    logic signed [10:0] y_ext, err, aerr, mag, ypos;
    logic [3:0]         step;
    logic               up_req, dn_req, reversal;

    always_ff @(posedge clk_1ms or negedge reset) begin
        if (!reset) begin
            up_s1_q   <= 1'b1;
            up_s2_q   <= 1'b1;
            dn_s1_q   <= 1'b1;
            dn_s2_q   <= 1'b1;
            mode_s1_q <= 1'b0;
            mode_s2_q <= 1'b0;
            state_q   <= IDLE;
            y_q       <= 10'(V_ACTIVE / 2);
            speed_q   <= 4'd1;
            cnt_q     <= '0;
            top_q     <= 1'b0;
            bot_q     <= 1'b0;
        end else begin
            up_s1_q   <= btn_up_n;
            up_s2_q   <= up_s1_q;
            dn_s1_q   <= btn_dn_n;
            dn_s2_q   <= dn_s1_q;
            mode_s1_q <= auto_mode;
            mode_s2_q <= mode_s1_q;
            state_q   <= state_d;
            y_q       <= y_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
            top_q     <= top_d;
            bot_q     <= bot_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        y_d      = y_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        y_ext    = {1'b0, y_q};
        ypos     = y_ext;
        err      = $signed({1'b0, ball_y}) - y_ext;
        aerr     = err[10] ? -err : err;
        mag      = (aerr < AUTO_S) ? aerr : AUTO_S;
        up_req   = ~up_s2_q;
        dn_req   = ~dn_s2_q;
        reversal = 1'b0;
        step     = speed_q;
        cnt_inc  = cnt_q + CW'(1);

        // mode_s2 is about to take a new value: hold this edge, the new mode starts next edge
        if (mode_s1_q != mode_s2_q) begin
            speed_d = 4'd1;
            cnt_d   = '0;
        end else if (mode_s2_q) begin
            speed_d = 4'd1;
            cnt_d   = '0;
            if (aerr > DZ_S) begin
                ypos = err[10] ? (y_ext - mag) : (y_ext + mag);
            end
        end else begin
            if (up_req && !dn_req && (y_ext > YMIN_S)) begin
                state_d = UP;
            end else if (dn_req && !up_req && (y_ext < YMAX_S)) begin
                state_d = DOWN;
            end

            if (state_d == IDLE) begin
                speed_d = 4'd1;
                cnt_d   = '0;
            end else begin
                reversal = (state_q != IDLE) && (state_q != state_d);
                if (reversal) begin
                    step    = 4'd1;
                    speed_d = 4'd1;
                    cnt_d   = '0;
                end else if (cnt_inc == CW'(ACCEL_MS)) begin
                    cnt_d   = '0;
                    speed_d = (speed_q >= 4'(MAX_SPEED)) ? speed_q : speed_q + 4'd1;
                end else begin
                    cnt_d   = cnt_inc;
                end
                ypos = (state_d == UP) ? (y_ext - $signed({7'd0, step}))
                                       : (y_ext + $signed({7'd0, step}));
            end
        end

        if (ypos < YMIN_S) begin
            ypos = YMIN_S;
        end else if (ypos > YMAX_S) begin
            ypos = YMAX_S;
        end
        y_d = ypos[9:0];

        // arriving at a limit under manual control restarts the ramp
        if ((state_d != IDLE) && ((ypos == YMIN_S) || (ypos == YMAX_S))) begin
            speed_d = 4'd1;
            cnt_d   = '0;
        end

        top_d = (ypos == YMIN_S);
        bot_d = (ypos == YMAX_S);
    end

    logic [10:0] px_ext, py_ext;
    assign px_ext = {1'b0, pix.x};
    assign py_ext = {1'b0, pix.y};

    assign pix.paddle_on = (px_ext >= 11'(X_CENTER - PADDLE_W / 2))
                        && (px_ext <  11'(X_CENTER + PADDLE_W / 2))
                        && (px_ext <  11'(H_ACTIVE))
                        && (py_ext >= ({1'b0, y_q} - 11'(PADDLE_H / 2)))
                        && (py_ext <  ({1'b0, y_q} + 11'(PADDLE_H / 2)));
    assign pix.rgb_paddle = COLOR;

    assign x_paddle  = 10'(X_CENTER);
    assign y_paddle  = y_q;
    assign speed     = speed_q;
    assign at_top    = top_q;
    assign at_bottom = bot_q;
endmodule
